id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
Decode stage plus ID/EX pipeline register directly upstream of the ALU (adder). It decodes a 32-bit MIPS instruction into the ALU's 4-bit ALUOp code, shamt and operand pair. It forwards the previous ALU result where needed and registers everything on the posedge of clock. The ALU then samples these registered values on the following negedge.

Parameters:
- REG_ZERO_FWD, 0, when 0 no forwarding from destination register $0; when 1 $0 is forwarded like any other register (debug only).

Ports:
- clock  in  1  system clock; register updates on posedge
- reset  in  1  synchronous, active-high
- instr_valid  in  1  instr holds a real instruction this cycle
- instr  in  32  fetched instruction word
- rs_data  in  32  register-file read data for instr[25:21]
- rt_data  in  32  register-file read data for instr[20:16]
- stall  in  1  hold all outputs unchanged this cycle
- flush  in  1  replace the next register contents with a bubble
- ex_reg_write  in  1  instruction now in EX writes a register
- ex_dest  in  5  destination register of the instruction in EX
- ex_result  in  32  ALU result of the instruction in EX
- ALUOp  out  4  ALU operation code
- rs  out  32  ALU operand A
- rt  out  32  ALU operand B (register value or extended immediate)
- shamt  out  5  shift amount
- dest_reg  out  5  writeback register
- reg_write  out  1  writeback enable
- valid  out  1  slot holds a real instruction
- illegal  out  1  the instruction in the slot was not decodable

Behaviour:
- Reset: when reset=1 at posedge, all outputs go to 0 (ALUOp=0000 is the ALU's no-op). Reset overrides flush and stall.
- Update priority at each posedge: reset > flush > stall > load.
  - flush: load a bubble (all outputs 0). This applies even if stall is also 1.
  - stall: all outputs hold their current values.
  - load: outputs take the decoded instruction. Latency is exactly 1 cycle from instr to outputs.
- instr_valid=0 on load: load a bubble.
- ALUOp codes: 0000 none, 0001 ADD, 0010 SUB, 0011 AND, 0100 OR, 0101 NOR, 0110 SLT, 0111 SLL, 1000 SRL, 1001 SRA.
- R-type decode (opcode 000000), selected by funct:
  - add/addu (0x20/0x21) -> ADD
  - sub/subu (0x22/0x23) -> SUB
  - and 0x24 -> AND
  - or 0x25 -> OR
  - nor 0x27 -> NOR
  - slt 0x2A -> SLT
  - sll 0x00 -> SLL
  - srl 0x02 -> SRL
  - sra 0x03 -> SRA
  - dest_reg = instr[15:11]; shamt = instr[10:6] for shifts, otherwise 0.
- I-type decode, dest_reg = instr[20:16], shamt = 0:
  - addi/addiu (0x08/0x09) -> ADD, rt = sign-extended imm16
  - slti 0x0A -> SLT, rt = sign-extended imm16
  - andi 0x0C -> AND, rt = zero-extended imm16
  - ori 0x0D -> OR, rt = zero-extended imm16
- NOP: the all-zero instruction word gives ALUOp=0000, reg_write=0, valid=1.
- Any other opcode or funct: illegal=1, valid=1, ALUOp=0000, reg_write=0.
- reg_write=1 for every legal non-NOP instruction, except it is forced to 0 when dest_reg=0.
- Forwarding, decided combinationally before the register:
  - Condition: ex_reg_write=1 and ex_dest equals the source field and ex_dest≠0 (the ≠0 check is removed when REG_ZERO_FWD=1).
  - When the condition holds, ex_result replaces rs_data / rt_data for that source.
  - The rt register path only matters for R-type; an immediate always wins over a forwarded rt value.
- During stall, forwarding inputs are ignored; held outputs are not re-evaluated.

Test Plan:
- Reset: reset=1 for 2 cycles with instr=0x02328020 -> all outputs 0; then reset=0 -> next posedge ALUOp=0001, dest_reg=16, reg_write=1, valid=1.
- add $16,$17,$18 (0x02328020) with rs_data=5, rt_data=7 -> one cycle later rs=5, rt=7, ALUOp=0001.
- sra $8,$9,4 (0x00094103) -> ALUOp=1001, shamt=4, dest_reg=8.
- addi $9,$0,-1 (0x2009FFFF) -> rt=0xFFFFFFFF, ALUOp=0001.
- andi $9,$0,0xFFFF (0x3009FFFF) -> rt=0x0000FFFF, ALUOp=0011.
- Forwarding: ex_reg_write=1, ex_dest=17, ex_result=0x1234, with add above -> rs=0x1234.
  - Same with ex_dest=0 -> rs=rs_data.
- Stall/flush: load the add, then stall=1 for 3 cycles with a new instr -> outputs unchanged; then stall=1 and flush=1 together -> bubble (valid=0, ALUOp=0000).
- Illegal: opcode 0x3F -> illegal=1, valid=1, ALUOp=0000, reg_write=0.
- Write to $0: add $0,$1,$2 -> reg_write=0.

Source files
------------

// File: rtl/id_ex_stage_if.sv
// Decode-side request and ID/EX register contents shared between the decode stage and its neighbours.
interface id_ex_stage_if;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        stall;
    logic        flush;
    logic        ex_reg_write;
    logic [4:0]  ex_dest;
    logic [31:0] ex_result;
    logic [3:0]  ALUOp;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [4:0]  shamt;
    logic [4:0]  dest_reg;
    logic        reg_write;
    logic        valid;
    logic        illegal;

    modport master (
        output instr_valid, instr, rs_data, rt_data, stall, flush,
               ex_reg_write, ex_dest, ex_result,
        input  ALUOp, rs, rt, shamt, dest_reg, reg_write, valid, illegal
    );

    modport slave (
        input  instr_valid, instr, rs_data, rt_data, stall, flush,
               ex_reg_write, ex_dest, ex_result,
        output ALUOp, rs, rt, shamt, dest_reg, reg_write, valid, illegal
    );
endinterface

// File: rtl/id_ex_stage.sv
// MIPS decode plus ID/EX pipeline register feeding the ALU: decodes ALUOp/operands,
// forwards the EX result into the source operands, and registers everything on posedge clock.
module id_ex_stage #(
    parameter bit REG_ZERO_FWD = 1'b0
) (
    input logic          clock,
    input logic          reset,
    id_ex_stage_if.slave bus
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 4;
    localparam int unsigned RW   = 5;

    localparam logic [OPW-1:0] ALU_NONE = 4'd0;
    localparam logic [OPW-1:0] ALU_ADD  = 4'd1;
    localparam logic [OPW-1:0] ALU_SUB  = 4'd2;
    localparam logic [OPW-1:0] ALU_AND  = 4'd3;
    localparam logic [OPW-1:0] ALU_OR   = 4'd4;
    localparam logic [OPW-1:0] ALU_NOR  = 4'd5;
    localparam logic [OPW-1:0] ALU_SLT  = 4'd6;
    localparam logic [OPW-1:0] ALU_SLL  = 4'd7;
    localparam logic [OPW-1:0] ALU_SRL  = 4'd8;
    localparam logic [OPW-1:0] ALU_SRA  = 4'd9;

    logic [5:0]      opcode;
    logic [5:0]      funct;
    logic [RW-1:0]   rs_idx;
    logic [RW-1:0]   rt_idx;
    logic            fwd_rs_c;
    logic            fwd_rt_c;
    logic [XLEN-1:0] op_a_c;
    logic [XLEN-1:0] op_b_c;
    logic [XLEN-1:0] imm_sx_c;
    logic [XLEN-1:0] imm_zx_c;

    logic [OPW-1:0]  d_aluop;
    logic [XLEN-1:0] d_rs;
    logic [XLEN-1:0] d_rt;
    logic [RW-1:0]   d_shamt;
    logic [RW-1:0]   d_dest;
    logic            d_rw;
    logic            d_illegal;
    logic            d_nop;

    assign opcode   = bus.instr[31:26];
    assign funct    = bus.instr[5:0];
    assign rs_idx   = bus.instr[25:21];
    assign rt_idx   = bus.instr[20:16];
    assign imm_sx_c = {{16{bus.instr[15]}}, bus.instr[15:0]};
    assign imm_zx_c = {16'h0000, bus.instr[15:0]};

    // Bypass the EX result when it targets a source; $0 is only bypassed in debug builds.
    assign fwd_rs_c = bus.ex_reg_write && (bus.ex_dest == rs_idx) && (REG_ZERO_FWD || (bus.ex_dest != '0));
    assign fwd_rt_c = bus.ex_reg_write && (bus.ex_dest == rt_idx) && (REG_ZERO_FWD || (bus.ex_dest != '0));
    assign op_a_c   = fwd_rs_c ? bus.ex_result : bus.rs_data;
    assign op_b_c   = fwd_rt_c ? bus.ex_result : bus.rt_data;

    always_comb begin
        d_aluop   = ALU_NONE;
        d_rs      = op_a_c;
        d_rt      = op_b_c;
        d_shamt   = '0;
        d_dest    = '0;
        d_illegal = 1'b0;
        d_nop     = (bus.instr == '0);
        if (!d_nop) begin
            case (opcode)
                6'h00: begin
                    d_dest = bus.instr[15:11];
                    case (funct)
                        6'h20, 6'h21: d_aluop = ALU_ADD;
                        6'h22, 6'h23: d_aluop = ALU_SUB;
                        6'h24:        d_aluop = ALU_AND;
                        6'h25:        d_aluop = ALU_OR;
                        6'h27:        d_aluop = ALU_NOR;
                        6'h2A:        d_aluop = ALU_SLT;
                        6'h00: begin d_aluop = ALU_SLL; d_shamt = bus.instr[10:6]; end
                        6'h02: begin d_aluop = ALU_SRL; d_shamt = bus.instr[10:6]; end
                        6'h03: begin d_aluop = ALU_SRA; d_shamt = bus.instr[10:6]; end
                        default:      d_illegal = 1'b1;
                    endcase
                end
                6'h08, 6'h09: begin d_aluop = ALU_ADD; d_rt = imm_sx_c; d_dest = rt_idx; end
                6'h0A:        begin d_aluop = ALU_SLT; d_rt = imm_sx_c; d_dest = rt_idx; end
                6'h0C:        begin d_aluop = ALU_AND; d_rt = imm_zx_c; d_dest = rt_idx; end
                6'h0D:        begin d_aluop = ALU_OR;  d_rt = imm_zx_c; d_dest = rt_idx; end
                default:      d_illegal = 1'b1;
            endcase
        end
        // NOP and undecodable words carry no operands into EX.
        if (d_nop || d_illegal) begin
            d_aluop = ALU_NONE;
            d_rs    = '0;
            d_rt    = '0;
            d_shamt = '0;
            d_dest  = '0;
        end
        d_rw = !d_nop && !d_illegal && (d_dest != '0);
    end

    always_ff @(posedge clock) begin
        if (reset || bus.flush || (!bus.stall && !bus.instr_valid)) begin
            bus.ALUOp     <= ALU_NONE;
            bus.rs        <= '0;
            bus.rt        <= '0;
            bus.shamt     <= '0;
            bus.dest_reg  <= '0;
            bus.reg_write <= 1'b0;
            bus.valid     <= 1'b0;
            bus.illegal   <= 1'b0;
        end else if (!bus.stall) begin
            bus.ALUOp     <= d_aluop;
            bus.rs        <= d_rs;
            bus.rt        <= d_rt;
            bus.shamt     <= d_shamt;
            bus.dest_reg  <= d_dest;
            bus.reg_write <= d_rw;
            bus.valid     <= 1'b1;
            bus.illegal   <= d_illegal;
        end
    end
endmodule
